// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with load, prescaler, wrap/saturate bounds,
// compare match and a delayed one-cycle terminal-count pulse.
module counter_updown_param #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clear,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               dir,
    input  logic               sat,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   cmp_val,
    output logic [WIDTH-1:0]   q,
    output logic               match,
    output logic               tc,
    output logic               wrapped
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0]   q_q, q_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               evt_q, evt_d;
    logic               tc_q, tc_d;
    logic               wrapped_q, wrapped_d;
    logic               tick;

    // evt_q remembers that the last step hit a bound; tc follows one edge later.
    always_comb begin
        q_d       = q_q;
        cnt_d     = cnt_q;
        wrapped_d = wrapped_q;
        evt_d     = 1'b0;
        tc_d      = evt_q;
        tick      = 1'b0;
        if (clear) begin
            q_d       = '0;
            cnt_d     = '0;
            wrapped_d = 1'b0;
            tc_d      = 1'b0;
        end else if (load) begin
            q_d   = load_val;
            cnt_d = '0;
            tc_d  = 1'b0;
        end else if (en) begin
            if (cnt_q == presc) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (tick) begin
                if (dir) begin
                    if (q_q == MAX) begin
                        evt_d = 1'b1;
                        if (!sat) begin
                            q_d       = '0;
                            wrapped_d = 1'b1;
                        end
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end else begin
                    if (q_q == '0) begin
                        evt_d = 1'b1;
                        if (!sat) begin
                            q_d       = MAX;
                            wrapped_d = 1'b1;
                        end
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            cnt_q     <= '0;
            evt_q     <= 1'b0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            evt_q     <= evt_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign q       = q_q;
    assign match   = (q_q == cmp_val);
    assign tc      = tc_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed self-checking bench for counter_updown_param (WIDTH=8, PRESC_W=4).
module tb_counter_updown_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clear, load, dir, sat;
    logic [7:0] load_val, cmp_val;
    logic [3:0] presc;
    logic [7:0] q;
    logic       match, tc, wrapped;

    int checks = 0;
    int passes = 0;

    counter_updown_param #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .load(load),
        .load_val(load_val), .dir(dir), .sat(sat), .presc(presc),
        .cmp_val(cmp_val), .q(q), .match(match), .tc(tc), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_q(input string name, input logic [7:0] exp);
        checks++;
        if (q !== exp) $display("[TB] FAIL %s: q=%h expected %h", name, q, exp);
        else passes++;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0; dir = 1'b1; sat = 1'b0;
        load_val = 8'h00; cmp_val = 8'h00; presc = 4'd0;
        #12;
        check_q("reset_q", 8'h00);
        check_bit("reset_tc", tc, 1'b0);
        check_bit("reset_wrapped", wrapped, 1'b0);
        check_bit("reset_match_0", match, 1'b1);
        cmp_val = 8'h05;
        #1;
        check_bit("reset_match_5", match, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            edge_step();
            check_q($sformatf("enable_q%0d", i), 8'(i));
            check_bit("enable_tc", tc, 1'b0);
            check_bit("enable_wrapped", wrapped, 1'b0);
        end
    endtask

    task automatic test_prescaler();
        clear = 1'b1;
        edge_step();
        clear = 1'b0;
        presc = 4'd3;
        for (int k = 1; k <= 12; k++) begin
            edge_step();
            check_q($sformatf("presc_edge%0d", k), 8'(k / 4));
        end
        edge_step();
        edge_step();
        en = 1'b0;
        edge_step();
        edge_step();
        check_q("presc_hold", 8'h03);
        en = 1'b1;
        edge_step();
        check_q("presc_delayed_not_yet", 8'h03);
        edge_step();
        check_q("presc_delayed_step", 8'h04);
    endtask

    task automatic test_wrap();
        presc = 4'd0; load_val = 8'hFE; load = 1'b1;
        edge_step();
        load = 1'b0;
        check_q("wrap_load", 8'hFE);
        dir = 1'b1; sat = 1'b0;
        edge_step();
        check_q("wrap_up_ff", 8'hFF);
        check_bit("wrap_up_ff_tc", tc, 1'b0);
        edge_step();
        check_q("wrap_up_00", 8'h00);
        check_bit("wrap_up_00_tc", tc, 1'b0);
        check_bit("wrap_up_wrapped", wrapped, 1'b1);
        en = 1'b0;
        edge_step();
        check_bit("wrap_up_tc_pulse", tc, 1'b1);
        check_q("wrap_up_hold", 8'h00);
        edge_step();
        check_bit("wrap_up_tc_end", tc, 1'b0);
        dir = 1'b0; en = 1'b1;
        edge_step();
        check_q("wrap_down_ff", 8'hFF);
        check_bit("wrap_down_tc_early", tc, 1'b0);
        en = 1'b0;
        edge_step();
        check_bit("wrap_down_tc_pulse", tc, 1'b1);
        edge_step();
        check_bit("wrap_down_tc_end", tc, 1'b0);
        check_bit("wrap_down_wrapped", wrapped, 1'b1);
    endtask

    task automatic test_saturate();
        clear = 1'b1;
        edge_step();
        clear = 1'b0;
        check_bit("sat_clear_wrapped", wrapped, 1'b0);
        load_val = 8'h01; load = 1'b1;
        edge_step();
        load = 1'b0; dir = 1'b0; sat = 1'b1; en = 1'b1;
        edge_step();
        check_q("sat_step1", 8'h00);
        check_bit("sat_step1_tc", tc, 1'b0);
        edge_step();
        check_q("sat_hold1", 8'h00);
        check_bit("sat_hold1_tc", tc, 1'b0);
        edge_step();
        check_q("sat_hold2", 8'h00);
        check_bit("sat_hold2_tc", tc, 1'b1);
        check_bit("sat_wrapped", wrapped, 1'b0);
        en = 1'b0;
        edge_step();
        check_bit("sat_last_tc", tc, 1'b1);
        edge_step();
        check_bit("sat_tc_end", tc, 1'b0);
        check_bit("sat_wrapped_end", wrapped, 1'b0);
        sat = 1'b0;
    endtask

    task automatic test_priority();
        presc = 4'd0; dir = 1'b1; load_val = 8'hFF; load = 1'b1; en = 1'b1;
        edge_step();
        load = 1'b0;
        edge_step();
        check_bit("prio_pre_wrapped", wrapped, 1'b1);
        clear = 1'b1; load = 1'b1; load_val = 8'h55;
        edge_step();
        check_q("prio_clear_q", 8'h00);
        check_bit("prio_clear_wrapped", wrapped, 1'b0);
        check_bit("prio_clear_tc", tc, 1'b0);
        clear = 1'b0;
        edge_step();
        check_q("prio_load_q", 8'h55);
        load = 1'b0; presc = 4'd2;
        edge_step();
        check_q("prio_presc1", 8'h55);
        edge_step();
        check_q("prio_presc2", 8'h55);
        edge_step();
        check_q("prio_presc3", 8'h56);
    endtask

    task automatic test_match_reset();
        presc = 4'd0; dir = 1'b1; sat = 1'b0; en = 1'b1; cmp_val = 8'h10;
        load_val = 8'hFF; load = 1'b1;
        edge_step();
        load = 1'b0;
        edge_step();
        load_val = 8'h0E; load = 1'b1;
        edge_step();
        load = 1'b0;
        check_bit("match_0e", match, 1'b0);
        edge_step();
        check_bit("match_0f", match, 1'b0);
        edge_step();
        check_q("match_q10", 8'h10);
        check_bit("match_10", match, 1'b1);
        edge_step();
        check_bit("match_11", match, 1'b0);
        load_val = 8'h10; load = 1'b1;
        edge_step();
        load = 1'b0; en = 1'b0;
        check_bit("match_reload_10", match, 1'b1);
        check_bit("match_pre_wrapped", wrapped, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_q("async_reset_q", 8'h00);
        check_bit("async_reset_tc", tc, 1'b0);
        check_bit("async_reset_wrapped", wrapped, 1'b0);
        check_bit("async_reset_match", match, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_wrap();
        test_saturate();
        test_priority();
        test_match_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/counter_updown_param.md
# counter_updown_param

Parametrised up/down counter with load, programmable prescaler, wrap/saturate mode, compare match and terminal-count reporting. It generalises the team's fixed 8-bit load/enable counter. It sits directly behind the top-level pin wrapper, with control from `ui_in`/`uio_in` and `q` driven onto `uo_out`.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits (≥2).
- `PRESC_W`, 4: prescaler divisor width in bits (≥1).

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable; gates the prescaler and stepping.
- `clear`  in  1: synchronous clear.
- `load`  in  1: synchronous load of `load_val`.
- `load_val`  in  WIDTH: value for load.
- `dir`  in  1: 1 = count up, 0 = count down.
- `sat`  in  1: 0 = wrap at bounds, 1 = saturate at bounds.
- `presc`  in  PRESC_W: step once every `presc`+1 enabled cycles.
- `cmp_val`  in  WIDTH: compare value.
- `q`  out  WIDTH: counter value, registered.
- `match`  out  1: combinational, `q == cmp_val`.
- `tc`  out  1: registered one-cycle terminal-count pulse.
- `wrapped`  out  1: sticky flag, set on any wrap event.

## Operation
- **Reset** (`rst_n` = 0, async): `q`=0, prescaler count=0, `tc`=0, `wrapped`=0. `match` reflects 0 == `cmp_val`.
- **Per-edge priority**: `clear` > `load` > step. Only one action takes effect per cycle.
- **`clear`**:
  - `q` ← 0, prescaler ← 0, `wrapped` ← 0, `tc` ← 0.
  - Effective regardless of `en`.
- **`load`**:
  - `q` ← `load_val`, prescaler ← 0, `tc` ← 0.
  - `wrapped` is unchanged.
  - Effective regardless of `en`.
- **Prescaler**:
  - With `en`=1 and no clear/load, the prescaler count (PRESC_W bits) increments each cycle.
  - When count == `presc`, a tick occurs and the count returns to 0.
  - `presc`=0 gives a tick every enabled cycle.
  - With `en`=0, the prescaler holds.
  - If `presc` changes to below the current count, the next tick occurs when the count wraps past 2^PRESC_W−1 back to `presc`. No special handling is provided.
- **Step** (on tick):
  - Up, `q` < MAX: `q`+1.
  - Up, `q` == MAX (2^WIDTH−1): wrap to 0 if `sat`=0 (wrap event); hold MAX if `sat`=1 (saturate event).
  - Down, `q` > 0: `q`−1.
  - Down, `q` == 0: wrap to MAX if `sat`=0 (wrap event); hold 0 if `sat`=1 (saturate event).
- **`tc`**:
  - Registered. High for exactly the one cycle following a step that was a wrap or saturate event. Low otherwise.
  - Repeated saturate ticks give repeated pulses.
- **`wrapped`**: set by a wrap event only (not by saturate); cleared only by `clear` or reset.
- `dir` and `sat` are sampled at each tick. Changing them mid-count takes effect on the next tick.
- `load_val` outside the range is impossible by width. All arithmetic is modulo 2^WIDTH.

## Timing
- `q` changes on the rising edge where a tick is evaluated. Latency from `load`/`clear` assertion to `q` update is 1 edge.
- From reset release with `en`=1 held, the first step appears after `presc`+1 edges. Subsequent steps follow every `presc`+1 edges.
- `tc` rises on the edge after the edge that performed the boundary step, i.e. 1 cycle after `q` reaches or holds the bound.
- `match` has zero latency relative to `q`.
- Reset is asynchronous on assertion. Deassertion is assumed synchronised upstream.
- Reset mid-count forces all outputs to reset values immediately, with no pending `tc`.

## Test plan
- **Reset/enable**: WIDTH=8, `presc`=0, `dir`=1, `en`=1 for 5 edges after reset → `q` = 1, 2, 3, 4, 5; `tc`=0; `wrapped`=0.
- **Prescaler**: `presc`=3, `en`=1 → `q` increments on edges 4, 8, 12. Drop `en` for 2 cycles at prescaler count 2 → the next step is delayed by exactly 2 cycles.
- **Wrap up/down**:
  - `load` 8'hFE, `dir`=1, `sat`=0 → `q` = FF, 00; `tc` pulses one cycle after 00; `wrapped`=1.
  - Then `dir`=0 → `q` = FF on the next step; `tc` pulses again.
- **Saturate**: `load` 8'h01, `dir`=0, `sat`=1 → `q` = 00, 00, 00; `tc` pulses after each hold step; `wrapped` stays 0.
- **Priority**: `clear`, `load` (`load_val` 8'h55) and a tick in the same cycle → `q`=00, `wrapped`=0. Next cycle `load` alone → `q`=55. Both are ignored by the prescaler count, which restarts at 0.
- **Match/async reset**: `cmp_val`=8'h10, count up from 0E → `match` is high exactly while `q`=10. Assert `rst_n`=0 mid-cycle with `q`=10 → `q`=0, `tc`=0 and `wrapped`=0 immediately, without waiting for a clock edge.
